prog_loader: RTL
================

# prog_loader

Serial program loader that receives a framed instruction image over a UART line (8N1) and writes it into the CPU's 2K x 16 instruction memory through that memory's write port. It sits between the board's UART RX pin and the write side of the instruction RAM that the CPU reads. It holds the CPU in reset for the duration of a load and releases it only after a frame passes its checksum.

## Interface
Parameters:
- CLKS_PER_BIT, 234, clock cycles per UART bit (27 MHz / 115200); must be >= 4.
- TIMEOUT_CLKS, 2700000, maximum idle cycles between bytes inside a frame (100 ms at 27 MHz).
- ADDR_W, 11, instruction memory address width.
- DATA_W, 16, instruction word width; fixed at 16 (two bytes per word).

Ports:
- clk  in  1  system clock; single clock domain.
- rst  in  1  reset, synchronous, active-high.
- uart_rx  in  1  asynchronous serial input, idle high.
- mem_we  out  1  one-cycle write strobe to instruction memory.
- mem_adr  out  ADDR_W  write address.
- mem_din  out  DATA_W  write data.
- cpu_rst_n  out  1  active-low reset to the CPU.
- busy  out  1  high while a frame is in progress.
- done  out  1  sticky: last frame loaded and verified.
- err  out  1  sticky: last frame failed.

## Operation
- Reset values: mem_we=0, mem_adr=0, mem_din=0, cpu_rst_n=1, busy=0, done=0, err=0; RX and frame FSMs in IDLE.
- RX front end: uart_rx through a 2-flop synchronizer. Falling edge in RX_IDLE starts a bit timer; re-sample at CLKS_PER_BIT/2: if high, false start, return to RX_IDLE. Then sample 8 data bits LSB first at CLKS_PER_BIT intervals, then stop bit. Stop=1 -> internal byte_valid pulse for one cycle with byte. Stop=0 -> framing-error pulse, no byte.
- Frame format: 0xA5 sync, LEN_LO, LEN_HI (word count N, 16-bit little-endian), N words each as LO then HI byte, CSUM. CSUM must equal mod-256 sum of all bytes from LEN_LO through last data byte.
- Frame FSM states: IDLE, LEN_LO, LEN_HI, DATA_LO, DATA_HI, CSUM.
  - IDLE: bytes other than 0xA5 ignored. On 0xA5: cpu_rst_n=0, busy=1, done=0, err=0, mem_adr=0, sum=0, go LEN_LO.
  - LEN_LO -> LEN_HI. LEN_HI: N > 2**ADDR_W -> error; N = 0 -> CSUM; else DATA_LO.
  - DATA_LO latches low byte -> DATA_HI. DATA_HI: mem_din={hi,lo}, mem_we pulse; remaining count decrements; zero -> CSUM, else DATA_LO.
  - CSUM: match -> done=1, busy=0, cpu_rst_n=1, IDLE. Mismatch -> error.
- Error action (checksum mismatch, length overflow, framing error in any non-IDLE state, inter-byte timeout): err=1, busy=0, done=0, cpu_rst_n stays 0, FSM to IDLE. CPU remains in reset until a later frame succeeds.
- Framing error while FSM in IDLE: ignored, err unchanged.
- Timeout counter clears on every byte_valid; counts only when FSM not IDLE; reaching TIMEOUT_CLKS triggers error.
- mem_adr increments by 1 the cycle after each write; wraps never reached because N is bounded to 2**ADDR_W (address after the last permitted word is not written).
- rst mid-frame: everything returns to reset values, including cpu_rst_n=1; partially written memory is not restored.

## Timing
- byte_valid asserts the cycle after the mid-stop-bit sample; total byte latency about 9.5 bit times from start edge.
- Frame FSM acts on byte_valid in the same cycle (registered outputs visible next cycle).
- mem_we high exactly one cycle, the cycle after HI byte byte_valid; mem_adr and mem_din stable during that cycle; mem_adr advances on the following cycle.
- cpu_rst_n falls the cycle after sync byte_valid; rises the cycle after CSUM byte_valid when matching.
- done/err hold until next sync byte or rst.
- Maximum of one write per 20 bit times; memory write port needs no backpressure.

## Test plan
- Reset: assert rst 2 cycles with uart_rx=1 -> all outputs at reset values; no mem_we for 10 bit times.
- Good frame A5 02 00 34 12 78 56 16 -> mem_we pulses at adr 0 data 0x1234, adr 1 data 0x5678; done=1, err=0, cpu_rst_n low from sync to after CSUM then 1.
- Same frame with CSUM 0x17 -> two writes occur, err=1, done=0, cpu_rst_n stays 0; then resend good frame -> done=1, cpu_rst_n=1.
- Noise 00 FF 5A before good frame, plus 1/4-bit glitch low on uart_rx -> ignored; frame loads as above.
- Length A5 01 08 -> err=1 right after LEN_HI, no mem_we; A5 00 00 00 -> done=1, no writes.
- Timeout: A5 01 00 then silence (TIMEOUT_CLKS reduced to 1000 in bench) -> err=1 at 1000 cycles after last byte_valid; stop bit forced low during DATA_LO -> err=1.

Source files
------------

// File: rtl/prog_loader.sv
// rtl/prog_loader.sv - UART 8N1 framed image loader into 2K x 16 instruction RAM
// Holds the CPU in reset while a frame loads and releases it only on a good checksum.
module prog_loader #(
   parameter int CLKS_PER_BIT = 234,
   parameter int TIMEOUT_CLKS = 2700000,
   parameter int ADDR_W       = 11,
   parameter int DATA_W       = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              uart_rx,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_adr,
   output logic [DATA_W-1:0] mem_din,
   output logic              cpu_rst_n,
   output logic              busy,
   output logic              done,
   output logic              err
);
   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam int TW = $clog2(TIMEOUT_CLKS);
   localparam int RW = ADDR_W + 1;
   localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);
   localparam logic [TW-1:0] TOUT_M1 = TW'(TIMEOUT_CLKS - 1);

   typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
   typedef enum logic [2:0] {F_IDLE, F_LEN_LO, F_LEN_HI, F_DATA_LO, F_DATA_HI, F_CSUM} f_state_t;

   logic            rx_s1, rx_s2, rx_prev;
   rx_state_t       rx_state_q, rx_state_d;
   logic [CW-1:0]   clk_cnt_q, clk_cnt_d;
   logic [2:0]      bit_idx_q, bit_idx_d;
   logic [7:0]      shreg_q, shreg_d;
   logic            byte_valid_q, byte_valid_d;
   logic            frame_err_q, frame_err_d;

   f_state_t          fstate_q, fstate_d;
   logic [7:0]        len_lo_q, len_lo_d;
   logic [7:0]        lo_q, lo_d;
   logic [7:0]        sum_q, sum_d;
   logic [RW-1:0]     remain_q, remain_d;
   logic [TW-1:0]     tout_q, tout_d;
   logic              mem_we_q, mem_we_d;
   logic [ADDR_W-1:0] mem_adr_q, mem_adr_d;
   logic [DATA_W-1:0] mem_din_q, mem_din_d;
   logic              cpu_rst_n_q, cpu_rst_n_d;
   logic              busy_q, busy_d, done_q, done_d, err_q, err_d;
   logic              fail;
   logic [15:0]       len_w;

   assign len_w = {shreg_q, len_lo_q};

   always_ff @(posedge clk) begin
      if (rst) begin
         rx_s1        <= 1'b1;
         rx_s2        <= 1'b1;
         rx_prev      <= 1'b1;
         rx_state_q   <= RX_IDLE;
         clk_cnt_q    <= '0;
         bit_idx_q    <= '0;
         shreg_q      <= '0;
         byte_valid_q <= 1'b0;
         frame_err_q  <= 1'b0;
      end else begin
         rx_s1        <= uart_rx;
         rx_s2        <= rx_s1;
         rx_prev      <= rx_s2;
         rx_state_q   <= rx_state_d;
         clk_cnt_q    <= clk_cnt_d;
         bit_idx_q    <= bit_idx_d;
         shreg_q      <= shreg_d;
         byte_valid_q <= byte_valid_d;
         frame_err_q  <= frame_err_d;
      end
   end

   always_comb begin
      rx_state_d   = rx_state_q;
      clk_cnt_d    = clk_cnt_q + 1'b1;
      bit_idx_d    = bit_idx_q;
      shreg_d      = shreg_q;
      byte_valid_d = 1'b0;
      frame_err_d  = 1'b0;
      case (rx_state_q)
         RX_IDLE: begin
            clk_cnt_d = '0;
            if (rx_prev && !rx_s2) rx_state_d = RX_START;
         end
         RX_START: if (clk_cnt_q == HALF_M1) begin
            clk_cnt_d  = '0;
            bit_idx_d  = '0;
            rx_state_d = rx_s2 ? RX_IDLE : RX_DATA;
         end
         RX_DATA: if (clk_cnt_q == FULL_M1) begin
            clk_cnt_d = '0;
            shreg_d   = {rx_s2, shreg_q[7:1]};
            bit_idx_d = bit_idx_q + 1'b1;
            if (bit_idx_q == 3'd7) rx_state_d = RX_STOP;
         end
         RX_STOP: if (clk_cnt_q == FULL_M1) begin
            clk_cnt_d    = '0;
            byte_valid_d = rx_s2;
            frame_err_d  = !rx_s2;
            rx_state_d   = RX_IDLE;
         end
         default: rx_state_d = RX_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         fstate_q    <= F_IDLE;
         len_lo_q    <= '0;
         lo_q        <= '0;
         sum_q       <= '0;
         remain_q    <= '0;
         tout_q      <= '0;
         mem_we_q    <= 1'b0;
         mem_adr_q   <= '0;
         mem_din_q   <= '0;
         cpu_rst_n_q <= 1'b1;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         fstate_q    <= fstate_d;
         len_lo_q    <= len_lo_d;
         lo_q        <= lo_d;
         sum_q       <= sum_d;
         remain_q    <= remain_d;
         tout_q      <= tout_d;
         mem_we_q    <= mem_we_d;
         mem_adr_q   <= mem_adr_d;
         mem_din_q   <= mem_din_d;
         cpu_rst_n_q <= cpu_rst_n_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         err_q       <= err_d;
      end
   end

   always_comb begin
      fstate_d    = fstate_q;
      len_lo_d    = len_lo_q;
      lo_d        = lo_q;
      sum_d       = sum_q;
      remain_d    = remain_q;
      mem_we_d    = 1'b0;
      mem_adr_d   = mem_we_q ? mem_adr_q + 1'b1 : mem_adr_q;
      mem_din_d   = mem_din_q;
      cpu_rst_n_d = cpu_rst_n_q;
      busy_d      = busy_q;
      done_d      = done_q;
      err_d       = err_q;
      fail        = 1'b0;
      tout_d      = (byte_valid_q || fstate_q == F_IDLE) ? '0 : tout_q + 1'b1;

      if (byte_valid_q) begin
         case (fstate_q)
            F_IDLE: if (shreg_q == 8'hA5) begin
               cpu_rst_n_d = 1'b0;
               busy_d      = 1'b1;
               done_d      = 1'b0;
               err_d       = 1'b0;
               mem_adr_d   = '0;
               sum_d       = '0;
               fstate_d    = F_LEN_LO;
            end
            F_LEN_LO: begin
               len_lo_d = shreg_q;
               sum_d    = sum_q + shreg_q;
               fstate_d = F_LEN_HI;
            end
            F_LEN_HI: begin
               sum_d = sum_q + shreg_q;
               if ({16'd0, len_w} > (32'd1 << ADDR_W)) fail = 1'b1;
               else if (len_w == 16'd0)                fstate_d = F_CSUM;
               else begin
                  remain_d = RW'(len_w);
                  fstate_d = F_DATA_LO;
               end
            end
            F_DATA_LO: begin
               lo_d     = shreg_q;
               sum_d    = sum_q + shreg_q;
               fstate_d = F_DATA_HI;
            end
            F_DATA_HI: begin
               sum_d     = sum_q + shreg_q;
               mem_din_d = DATA_W'({shreg_q, lo_q});
               mem_we_d  = 1'b1;
               remain_d  = remain_q - 1'b1;
               fstate_d  = (remain_q == RW'(1)) ? F_CSUM : F_DATA_LO;
            end
            F_CSUM: if (shreg_q == sum_q) begin
               done_d      = 1'b1;
               busy_d      = 1'b0;
               cpu_rst_n_d = 1'b1;
               fstate_d    = F_IDLE;
            end else fail = 1'b1;
            default: fstate_d = F_IDLE;
         endcase
      end else if (fstate_q != F_IDLE && (frame_err_q || tout_q == TOUT_M1)) begin
         fail = 1'b1;
      end

      // cpu_rst_n is deliberately left low: a failed image must not run
      if (fail) begin
         err_d    = 1'b1;
         busy_d   = 1'b0;
         done_d   = 1'b0;
         fstate_d = F_IDLE;
      end
   end

   assign mem_we    = mem_we_q;
   assign mem_adr   = mem_adr_q;
   assign mem_din   = mem_din_q;
   assign cpu_rst_n = cpu_rst_n_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign err       = err_q;
endmodule
